// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INST = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues held imem requests, buffers one instruction
// under stall and drains an in-flight request after a redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    Stall,
    input  logic                    Redirect,
    input  logic [XLEN-1:0]         Redirect_PC,
    if_fetch_unit_if.master         imem,
    output logic [XLEN-1:0]         PCP4_out,
    output logic [XLEN-1:0]         Inst_out,
    output logic                    Inst_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [XLEN-1:0] buf_inst_q, buf_inst_d;
    logic [XLEN-1:0] buf_pcp4_q, buf_pcp4_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;

    assign pc_plus4     = pc_q + PC_STEP;
    assign redirect_tgt = Redirect_PC & ~(XLEN'(3));

    // A request is live whenever we are not parked in HOLD or being reset.
    assign imem.imem_req  = !Reset && (state_q != ST_HOLD);
    assign imem.imem_addr = pc_q;

    assign PCP4_out   = pcp4_q;
    assign Inst_out   = inst_q;
    assign Inst_valid = valid_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            buf_inst_q   <= '0;
            buf_pcp4_q   <= '0;
            pcp4_q       <= '0;
            inst_q       <= NOP_INST;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_pcp4_q   <= buf_pcp4_d;
            pcp4_q       <= pcp4_d;
            inst_q       <= inst_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_pcp4_d   = buf_pcp4_q;
        pcp4_d       = pcp4_q;
        inst_d       = inst_q;
        valid_d      = valid_q;

        if (Redirect) begin
            pcp4_d  = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
            // An outstanding request cannot be aborted, so park the target until it returns.
            if ((state_q == ST_FETCH || state_q == ST_DRAIN) && !imem.imem_ready) begin
                pending_pc_d = redirect_tgt;
                state_d      = ST_DRAIN;
            end else begin
                pc_d    = redirect_tgt;
                state_d = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem.imem_ready) begin
                        pc_d = pc_plus4;
                        if (!Stall) begin
                            inst_d  = imem.imem_rdata;
                            pcp4_d  = pc_plus4;
                            valid_d = 1'b1;
                        end else begin
                            buf_inst_d = imem.imem_rdata;
                            buf_pcp4_d = pc_plus4;
                            state_d    = ST_HOLD;
                        end
                    end else if (!Stall) begin
                        pcp4_d  = '0;
                        inst_d  = NOP_INST;
                        valid_d = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!Stall) begin
                        inst_d  = buf_inst_q;
                        pcp4_d  = buf_pcp4_q;
                        valid_d = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    pcp4_d  = '0;
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (imem.imem_ready) begin
                        pc_d    = pending_pc_q;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: predictor pushes live fetches in program
// order, monitor pops whatever IF/ID takes on the falling edge.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        Reset, Stall, Redirect;
    logic [31:0] Redirect_PC;
    logic [31:0] PCP4_out, Inst_out;
    logic        Inst_valid;

    always #5 clk = ~clk;

    if_fetch_unit_if mif ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0000)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .Redirect_PC(Redirect_PC),
        .imem       (mif),
        .PCP4_out   (PCP4_out),
        .Inst_out   (Inst_out),
        .Inst_valid (Inst_valid)
    );

    // Memory image: each word encodes its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign mif.imem_rdata = mem_word(mif.imem_addr);

    int total = 0;
    int bad   = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_pc    = 32'h0;
    logic        poisoned  = 1'b0;
    logic        hold_chk  = 1'b0;
    logic [31:0] hold_addr = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Predictor: program-order model of which fetches must reach IF/ID.
    always @(posedge clk) begin
        if (Reset) begin
            sb_q.delete();
            exp_pc   <= 32'h0;
            poisoned <= 1'b0;
            hold_chk <= 1'b0;
        end else begin
            hold_chk  <= mif.imem_req && !mif.imem_ready;
            hold_addr <= mif.imem_addr;
            if (mif.imem_req && mif.imem_ready && !Redirect && !poisoned) begin
                chk("fetch_addr", mif.imem_addr, exp_pc);
                sb_q.push_back({exp_pc + 32'd4, mem_word(exp_pc)});
            end
            if (Redirect) begin
                sb_q.delete();
                exp_pc   <= Redirect_PC & 32'hFFFF_FFFC;
                poisoned <= mif.imem_req && !mif.imem_ready;
            end else if (mif.imem_req && mif.imem_ready) begin
                poisoned <= 1'b0;
                if (!poisoned) exp_pc <= exp_pc + 32'd4;
            end
        end
    end

    // Monitor: IF/ID captures on the falling edge unless Stall holds it.
    always @(negedge clk) begin
        logic [63:0] e;
        if (hold_chk && !Reset) begin
            chk("addr_stable", mif.imem_addr, hold_addr);
            chk("req_stable", 32'(mif.imem_req), 32'd1);
        end
        if (Inst_valid === 1'b1) begin
            if (!Stall) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got pcp4=%h inst=%h expected none", PCP4_out, Inst_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pcp4", PCP4_out, e[63:32]);
                    chk("sb_inst", Inst_out, e[31:0]);
                end
            end
        end else begin
            chk("bubble_valid", 32'(Inst_valid), 32'd0);
            chk("bubble_inst", Inst_out, 32'h0);
            chk("bubble_pcp4", PCP4_out, 32'h0);
        end
    end

    task automatic step(input logic rst, input logic st, input logic rd,
                        input logic [31:0] tgt, input logic rdy);
        Reset          = rst;
        Stall          = st;
        Redirect       = rd;
        Redirect_PC    = tgt;
        mif.imem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [31:0] pcp4, input logic [31:0] inst,
                           input logic vld, input logic [31:0] addr);
        chk({nm, "_pcp4"}, PCP4_out, pcp4);
        chk({nm, "_inst"}, Inst_out, inst);
        chk({nm, "_valid"}, 32'(Inst_valid), 32'(vld));
        chk({nm, "_addr"}, mif.imem_addr, addr);
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_out("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("reset_req", 32'(mif.imem_req), 32'd0);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("seq0", 32'd4, 32'hA5A5_0000, 1'b1, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("seq1", 32'd8, 32'hA5A5_0004, 1'b1, 32'd8);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            chk_out("hold", 32'd8, 32'hA5A5_0004, 1'b1, 32'd12);
            chk("hold_req", 32'(mif.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("release", 32'd12, 32'hA5A5_0008, 1'b1, 32'd12);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("seq3", 32'd16, 32'hA5A5_000C, 1'b1, 32'd16);

        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk_out("wait", 32'h0, 32'h0, 1'b0, 32'd16);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("wait_done", 32'd20, 32'hA5A5_0010, 1'b1, 32'd20);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0403, 1'b0);
        chk_out("drain", 32'h0, 32'h0, 1'b0, 32'd20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("drain_done", 32'h0, 32'h0, 1'b0, 32'h400);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("tgt", 32'h404, 32'hA5A5_0400, 1'b1, 32'h404);

        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("hold2_req", 32'(mif.imem_req), 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h800, 1'b1);
        chk_out("hold_redir", 32'h0, 32'h0, 1'b0, 32'h800);
        chk("hold_redir_req", 32'(mif.imem_req), 32'd1);

        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("wrap_addr", mif.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk_out("wrap", 32'h0, 32'h5A5A_FFFC, 1'b1, 32'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk_out("rst_drain", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_drain_req", 32'(mif.imem_req), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_rd, r_rdy;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 199) == 0);
            r_st  = ($urandom_range(0, 9) < 3);
            r_rd  = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7)))
                                                 : $urandom;
            step(r_rst, r_st, r_rd, r_tgt, r_rdy);
        end

        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        #1;
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
